// File: rtl/rotation_scheduler_pkg.sv
// rotation_scheduler_pkg: shared defaults, packed matrix/vertex types and FSM state enum
package rotation_scheduler_pkg;
  localparam int DEF_IN_BITS      = 8;
  localparam int DEF_SIZE         = 3;
  localparam int DEF_NUM_VERTS    = 8;
  localparam int DEF_MULT_LATENCY = 4;
  typedef logic [DEF_SIZE-1:0][DEF_IN_BITS-1:0] vec_t;
  typedef logic [DEF_SIZE-1:0][DEF_SIZE-1:0][DEF_IN_BITS-1:0] mat_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/rotation_scheduler_mult.sv
// rotation_scheduler_mult: pipelined truncating matrix multiplier, o_p = i_a * i_b after LATENCY cycles
//   i_clk, i_rst_n : clock, async active-low reset
//   i_a, i_b       : operand matrices [row][col]
//   o_p            : product [row][col], truncated to IN_BITS per element
module rotation_scheduler_mult
  import rotation_scheduler_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int SIZE    = DEF_SIZE,
  parameter int LATENCY = DEF_MULT_LATENCY
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] i_a,
  input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] i_b,
  output logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] o_p
);
  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] w_p;
  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] r_pipe [LATENCY];
  always_comb begin
    w_p = '0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        for (int k = 0; k < SIZE; k++)
          w_p[i][j] = w_p[i][j] + i_a[i][k] * i_b[k][j];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < LATENCY; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= w_p;
      for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end
  assign o_p = r_pipe[LATENCY-1];
endmodule

// File: rtl/rotation_scheduler.sv
// rotation_scheduler: batches vertices through an external matrix multiplier and streams rotated results
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start, i_rot      : job request (IDLE only) and rotation matrix captured with it
//   o_vert_rd_addr      : vertex store address; i_vert_rd_data returns one cycle later
//   o_mult_a, o_mult_b  : multiplier operands (rot, batch vertices as columns); i_mult_out product
//   o_res_valid/addr/data, i_res_ready : result stream handshake
//   o_busy, o_done      : job in progress, one-cycle completion pulse
module rotation_scheduler
  import rotation_scheduler_pkg::*;
#(
  parameter int IN_BITS      = DEF_IN_BITS,
  parameter int SIZE         = DEF_SIZE,
  parameter int NUM_VERTS    = DEF_NUM_VERTS,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] i_rot,
  output logic [$clog2(NUM_VERTS)-1:0]           o_vert_rd_addr,
  input  logic [SIZE-1:0][IN_BITS-1:0]           i_vert_rd_data,
  output logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] o_mult_a,
  output logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] o_mult_b,
  input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] i_mult_out,
  output logic                                  o_res_valid,
  output logic [$clog2(NUM_VERTS)-1:0]           o_res_addr,
  output logic [SIZE-1:0][IN_BITS-1:0]           o_res_data,
  input  logic                                  i_res_ready,
  output logic                                  o_busy,
  output logic                                  o_done
);
  localparam int AW = $clog2(NUM_VERTS);
  localparam int PW = $clog2(NUM_VERTS + 1);
  localparam int CW = $clog2((SIZE > MULT_LATENCY ? SIZE : MULT_LATENCY) + 1);
  localparam int SW = SIZE > 1 ? $clog2(SIZE) : 1;
  state_t                                 r_state;
  logic [PW-1:0]                          r_base;
  logic [CW-1:0]                          r_cnt;
  logic [AW-1:0]                          r_rd_addr, r_res_addr;
  logic                                   r_res_valid, r_done;
  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] r_rot, r_mult_b;
  logic [PW-1:0]                          w_rem;
  logic [CW-1:0]                          w_n;
  logic                                   w_last;
  logic [SW-1:0]                          w_slot, w_cap;
  logic [SIZE-1:0][IN_BITS-1:0]           w_col;
  assign w_rem  = PW'(NUM_VERTS) - r_base;
  assign w_n    = (w_rem > PW'(SIZE)) ? CW'(SIZE) : CW'(w_rem);
  assign w_last = w_rem <= PW'(SIZE);
  assign w_slot = SW'(r_cnt);
  // read data lags the address by one cycle, so FETCH cycle c captures vertex c-1
  assign w_cap  = SW'(r_cnt - CW'(1));
  always_comb begin
    w_col = '0;
    for (int i = 0; i < SIZE; i++) w_col[i] = i_mult_out[i][w_slot];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_res_addr  <= '0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_rot       <= '0;
      r_mult_b    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_rot     <= i_rot;
          r_base    <= '0;
          r_cnt     <= '0;
          r_rd_addr <= '0;
          r_mult_b  <= '0;
          r_state   <= S_FETCH;
        end
        S_FETCH: begin
          if (r_cnt != '0)
            for (int i = 0; i < SIZE; i++) r_mult_b[i][w_cap] <= i_vert_rd_data[i];
          if (r_cnt + CW'(1) < w_n) r_rd_addr <= AW'(r_base + PW'(r_cnt) + PW'(1));
          if (r_cnt == w_n) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else r_cnt <= r_cnt + CW'(1);
        end
        S_WAIT: if (r_cnt == CW'(MULT_LATENCY - 1)) begin
          r_cnt       <= '0;
          r_res_valid <= 1'b1;
          r_res_addr  <= AW'(r_base);
          r_state     <= S_DRAIN;
        end else r_cnt <= r_cnt + CW'(1);
        S_DRAIN: if (i_res_ready) begin
          if (r_cnt == w_n - CW'(1)) begin
            r_res_valid <= 1'b0;
            r_cnt       <= '0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_base    <= r_base + PW'(w_n);
              r_rd_addr <= AW'(r_base + PW'(w_n));
              r_mult_b  <= '0;
              r_state   <= S_FETCH;
            end
          end else begin
            r_cnt      <= r_cnt + CW'(1);
            r_res_addr <= r_res_addr + AW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_vert_rd_addr = r_rd_addr;
  assign o_mult_a       = r_rot;
  assign o_mult_b       = r_mult_b;
  assign o_res_valid    = r_res_valid;
  assign o_res_addr     = r_res_addr;
  assign o_res_data     = (r_state == S_DRAIN) ? w_col : '0;
  assign o_busy         = r_state != S_IDLE;
  assign o_done         = r_done;
endmodule

// File: tb/tb_rotation_scheduler.sv
// tb_rotation_scheduler: scoreboard bench for rotation_scheduler with the multiplier beside it
module tb_rotation_scheduler;
  import rotation_scheduler_pkg::*;
  localparam int NV  = DEF_NUM_VERTS;
  localparam int SZ  = DEF_SIZE;
  localparam int AW  = $clog2(NV);
  localparam int FB  = ((NV - 1) / SZ) * SZ;
  typedef struct {logic [AW-1:0] addr; vec_t data; bit last;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, res_ready = 0;
  mat_t rot = '0, ma, mb, mo, exp_rot = '0;
  vec_t rd_data = '0, res_data;
  logic [AW-1:0] rd_addr, res_addr;
  logic res_valid, busy, done;
  vec_t mem [NV];
  exp_t q[$];
  int tests = 0, fails = 0, done_cnt = 0, acc_cnt = 0, target = 0, ready_mode = 0, rcyc = 0;
  bit done_due = 0;
  rotation_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rot(rot),
    .o_vert_rd_addr(rd_addr), .i_vert_rd_data(rd_data),
    .o_mult_a(ma), .o_mult_b(mb), .i_mult_out(mo),
    .o_res_valid(res_valid), .o_res_addr(res_addr), .o_res_data(res_data),
    .i_res_ready(res_ready), .o_busy(busy), .o_done(done)
  );
  rotation_scheduler_mult mult (.i_clk(clk), .i_rst_n(rst_n), .i_a(ma), .i_b(mb), .o_p(mo));
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) begin
    #1;
    rcyc++;
    res_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rcyc % 3 == 0) : 1'($urandom_range(0, 1));
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t rotate(input mat_t r, input vec_t v);
    vec_t o;
    for (int i = 0; i < SZ; i++) begin
      int s = 0;
      for (int c = 0; c < SZ; c++) s += int'($signed(r[i][c])) * int'($signed(v[c]));
      o[i] = DEF_IN_BITS'(s);
    end
    return o;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (done || done_due) begin
        check("done_pulse", done, done_due);
        if (done) done_cnt++;
      end
      done_due = 0;
      if (res_valid) begin
        if (q.size() == 0) check("unexpected_result", res_valid, 0);
        else begin
          check("res_addr", res_addr, q[0].addr);
          check("res_data", res_data, q[0].data);
          check("mult_a", ma, exp_rot);
          if (int'(q[0].addr) >= FB)
            for (int j = NV - FB; j < SZ; j++)
              for (int i = 0; i < SZ; i++) check("pad_col", mb[i][j], 0);
          if (res_ready) begin
            done_due = q[0].last;
            void'(q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end
  task automatic start_job(input mat_t r);
    q.delete();
    for (int k = 0; k < NV; k++) q.push_back('{addr: AW'(k), data: rotate(r, mem[k]), last: (k == NV - 1)});
    exp_rot = r;
    target = done_cnt + 1;
    @(posedge clk); #2;
    start = 1; rot = r;
    @(posedge clk); #2;
    start = 0; rot = mat_t'({$urandom, $urandom, $urandom});
    check("busy_after_start", busy, 1);
  endtask
  task automatic wait_job(input int pulse_at);
    for (int c = 0; c < 600 && done_cnt < target; c++) begin
      @(posedge clk); #2;
      start = (c == pulse_at);
      if (start) rot = mat_t'({$urandom, $urandom, $urandom});
    end
    start = 0;
    check("job_done", done_cnt, target);
    repeat (6) @(posedge clk);
    #2;
    check("single_done", done_cnt, target);
    check("idle_busy", busy, 0);
    check("queue_empty", q.size(), 0);
  endtask
  task automatic reset_checks();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_addr", res_addr, 0);
    check("rst_res_data", res_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_mult_a", ma, 0);
    check("rst_mult_b", mb, 0);
  endtask
  task automatic rand_mem();
    for (int k = 0; k < NV; k++) mem[k] = vec_t'($urandom);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    mat_t r;
    vec_t e;
    int a0;
    for (int k = 0; k < NV; k++) begin
      mem[k][0] = DEF_IN_BITS'(k);
      mem[k][1] = DEF_IN_BITS'(k + 1);
      mem[k][2] = DEF_IN_BITS'(k + 2);
    end
    repeat (3) @(posedge clk);
    #2;
    reset_checks();
    rst_n = 1;
    r = '0;
    for (int i = 0; i < SZ; i++) r[i][i] = 8'd1;
    ready_mode = 0;
    start_job(r);
    wait_job(-1);
    rand_mem();
    mem[0][0] = 8'd1; mem[0][1] = 8'd2; mem[0][2] = 8'd3;
    r = '0;
    r[0][1] = 8'hFF; r[1][0] = 8'd1; r[2][2] = 8'd1;
    e[0] = 8'hFE; e[1] = 8'h01; e[2] = 8'h03;
    ready_mode = 1;
    start_job(r);
    q[0].data = e;
    wait_job(-1);
    for (int j = 0; j < 4; j++) begin
      rand_mem();
      ready_mode = j % 3;
      start_job(mat_t'({$urandom, $urandom, $urandom}));
      wait_job(j == 0 ? 10 : (j == 1 ? 25 : -1));
    end
    rand_mem();
    ready_mode = 0;
    a0 = acc_cnt;
    start_job(mat_t'({$urandom, $urandom, $urandom}));
    for (int c = 0; c < 200 && acc_cnt < a0 + SZ; c++) @(posedge clk);
    check("first_batch_drained", acc_cnt, a0 + SZ);
    repeat (5) @(posedge clk);
    #2;
    check("in_wait_busy", busy, 1);
    check("in_wait_no_valid", res_valid, 0);
    rst_n = 0;
    #1;
    reset_checks();
    q.delete();
    done_due = 0;
    repeat (2) @(posedge clk);
    #2;
    check("no_done_after_abort", done_cnt, target - 1);
    rst_n = 1;
    rand_mem();
    ready_mode = 2;
    start_job(mat_t'({$urandom, $urandom, $urandom}));
    wait_job(-1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rotation_scheduler.md
ROTATION_SCHEDULER -- requirements
Module: rotation_scheduler

Interface
REQ-001 Parameter: IN_BITS, default 8, element width of matrices and vertex components.
REQ-002 Parameter: SIZE, default 3, matrix dimension and vertices per multiply batch.
REQ-003 Parameter: NUM_VERTS, default 8, vertices rotated per job.
REQ-004 Parameter: MULT_LATENCY, default 4, cycles from operands stable to mult_out valid.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  job request, sampled in IDLE only.
REQ-008 rot  in  SIZE*SIZE*IN_BITS  rotation matrix [row][col], captured on accepted start.
REQ-009 vert_rd_addr  out  $clog2(NUM_VERTS)  vertex store read address.
REQ-010 vert_rd_data  in  SIZE*IN_BITS  vertex [component]; valid 1 cycle after vert_rd_addr.
REQ-011 mult_a  out  SIZE*SIZE*IN_BITS  multiplier operand A (registered rot).
REQ-012 mult_b  out  SIZE*SIZE*IN_BITS  multiplier operand B; column j = batch vertex j.
REQ-013 mult_out  in  SIZE*SIZE*IN_BITS  multiplier product A*B.
REQ-014 res_valid  out  1  result vertex available.
REQ-015 res_addr  out  $clog2(NUM_VERTS)  index of result vertex.
REQ-016 res_data  out  SIZE*IN_BITS  rotated vertex, component i = mult_out[i][j].
REQ-017 res_ready  in  1  consumer accepts result when high with res_valid.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse after final result accepted.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT, DRAIN, DONE.
REQ-021 IDLE->FETCH on start=1; rot registered, vertex pointer=0; start in any other state ignored.
REQ-022 FETCH SHALL issue SIZE consecutive addresses (fewer for the final partial batch) and write each returned vertex into mult_b column slot 0..SIZE-1, one per cycle.
REQ-023 Unused columns of the final partial batch SHALL be zero; NUM_VERTS=8, SIZE=3 gives batches 3,3,2.
REQ-024 FETCH->WAIT after last read data captured; mult_b SHALL remain stable throughout WAIT and DRAIN.
REQ-025 WAIT SHALL count exactly MULT_LATENCY cycles, then enter DRAIN.
REQ-026 DRAIN SHALL present batch results column 0 upward, res_valid=1, advancing only on res_valid&&res_ready; res_data/res_addr stable while stalled.
REQ-027 Padding columns SHALL never be presented.
REQ-028 DRAIN->FETCH after last valid column accepted if vertices remain, else DRAIN->DONE.
REQ-029 DONE SHALL assert done for one cycle and return to IDLE; start during DONE ignored.
REQ-030 Scheduler SHALL NOT modify data; width/overflow is the multiplier's (truncating) concern.
REQ-031 Throughput: one result per cycle in DRAIN with res_ready held high.

Reset
REQ-032 rst low SHALL immediately force IDLE from any state, aborting an in-flight job with no done pulse.
REQ-033 Reset values: busy=0, done=0, res_valid=0, res_addr=0, res_data=0, vert_rd_addr=0, mult_a=0, mult_b=0, counters=0.

Structure
REQ-034 Shared package SHALL hold IN_BITS/SIZE defaults, the packed matrix and vertex typedefs, and the state enum.
REQ-035 One sub-module SHALL be natural: the existing matrix multiplier, instantiated by the parent beside the scheduler, not inside it.

Verification
REQ-036 Identity rot, vertices k={k,k+1,k+2}, res_ready=1 -> results addr 0..7 equal inputs, done 1 cycle after addr 7 accepted.
REQ-037 rot = 90 deg about z {0,-1,0;1,0,0;0,0,1} (8-bit two's complement), vertex {1,2,3} -> {-2,1,3}.
REQ-038 res_ready toggled 1-of-3 cycles -> no result lost or duplicated, res_data stable while stalled.
REQ-039 Final batch -> mult_b column 2 = 0, only addrs 6 and 7 emitted.
REQ-040 rst low during WAIT of batch 2 -> outputs at reset values next cycle; new start runs full job correctly.
REQ-041 start pulsed while busy -> ignored, rot not re-captured, single done.
